// File: rtl/reg_scoreboard_pkg.sv
// Shared register-file definitions used by the scoreboard and its FIFO.
package reg_scoreboard_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_COUNT  = 32;

  typedef logic [REG_ADDR_W-1:0] rd_t;

  // x0 is hardwired; writes to it are placeholders and never create hazards.
  localparam rd_t ZERO_REG = '0;

  // One-hot decode of a register address; x0 never reports busy.
  function automatic logic [REG_COUNT-1:0] reg_onehot(input rd_t rd);
    logic [REG_COUNT-1:0] oh;
    oh = '0;
    if (rd != ZERO_REG) oh[rd] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/sb_fifo.sv
// Circular buffer of in-flight destination registers: push at tail, pop at head,
// drop the youngest entries from the tail, and report which slots hold live entries.
module sb_fifo
  import reg_scoreboard_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  rd_t              push_rd_i,
  input  logic             pop_i,
  input  logic [CNT_W-1:0] drop_i,
  output rd_t [DEPTH-1:0]  entries_o,
  output logic [DEPTH-1:0] valid_o,
  output logic [PTR_W-1:0] head_o,
  output logic [CNT_W-1:0] count_o
);

  rd_t [DEPTH-1:0]  mem_q, mem_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] offset;

  // Entry storage: write the new destination at the tail slot.
  always_comb begin
    mem_d = mem_q;
    if (push_i) mem_d[tail_q] = push_rd_i;
  end

  // Pointer and occupancy update; the caller never pushes and drops together.
  // A drop of DEPTH wraps the tail back onto itself, which is the intended result.
  always_comb begin
    head_d  = head_q + PTR_W'(pop_i);
    tail_d  = tail_q + PTR_W'(push_i) - drop_i[PTR_W-1:0];
    count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i) - drop_i;
  end

  // A slot is live when its distance from head is below the occupancy.
  always_comb begin
    offset = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset     = PTR_W'(i) - head_q;
      valid_o[i] = {1'b0, offset} < count_q;
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry contents are don't-care after reset, so storage has no reset.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign entries_o = mem_q;
  assign head_o    = head_q;
  assign count_o   = count_q;

endmodule

// File: rtl/reg_scoreboard.sv
// In-order register scoreboard: tracks destinations of in-flight instructions,
// stalls decode on RAW hazards, and supports partial flush of the youngest entries.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] rs1_address,
  input  logic [REG_ADDR_W-1:0] rs2_address,
  input  logic                  uses_rs1,
  input  logic                  uses_rs2,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  output logic                  stall,
  input  logic                  retire_valid,
  input  logic [REG_ADDR_W-1:0] retire_rd,
  input  logic                  flush,
  input  logic [CNT_W-1:0]      flush_count,
  output logic [CNT_W-1:0]      count,
  output logic [REG_COUNT-1:0]  busy_mask,
  output logic                  error
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  rd_t [DEPTH-1:0]  entries;
  logic [DEPTH-1:0] valid;
  logic [PTR_W-1:0] head;
  logic [CNT_W-1:0] fifo_count;

  logic [DEPTH-1:0] head_exempt, match1, match2;
  logic             hit1, hit2, full;
  logic             push, pop;
  logic [CNT_W-1:0] avail, drop;
  rd_t              head_rd;
  logic             error_q, error_d;

  sb_fifo #(
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) u_fifo (
    .clk_i    (clk),
    .reset_i  (reset),
    .push_i   (push),
    .push_rd_i(issue_rd),
    .pop_i    (pop),
    .drop_i   (drop),
    .entries_o(entries),
    .valid_o  (valid),
    .head_o   (head),
    .count_o  (fifo_count)
  );

  // Hazard detection; the retiring head entry is covered by the regfile write bypass.
  always_comb begin
    head_exempt = '0;
    if (retire_valid) head_exempt[head] = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      match1[i] = valid[i] && (entries[i] == rs1_address);
      match2[i] = valid[i] && (entries[i] == rs2_address);
    end
    hit1  = uses_rs1 && (rs1_address != ZERO_REG) && |(match1 & ~head_exempt);
    hit2  = uses_rs2 && (rs2_address != ZERO_REG) && |(match2 & ~head_exempt);
    full  = (fifo_count == CNT_W'(DEPTH)) && !retire_valid;
    stall = issue_valid && (hit1 || hit2 || full || flush);
  end

  // Queue control: flush blocks issue via stall, and drops only what survives the pop.
  always_comb begin
    head_rd = entries[head];
    pop     = retire_valid && (fifo_count != '0);
    push    = issue_valid && !stall;
    avail   = fifo_count - CNT_W'(pop);
    drop    = '0;
    if (flush) drop = (flush_count < avail) ? flush_count : avail;
  end

  // Busy mask from registered entries only.
  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i]) busy_mask = busy_mask | reg_onehot(entries[i]);
    end
  end

  // Sticky error on retire underflow or retire/head destination mismatch.
  always_comb begin
    error_d = error_q;
    if (retire_valid && ((fifo_count == '0) || (retire_rd != head_rd))) error_d = 1'b1;
  end

  // Error flag register.
  always_ff @(posedge clk) begin
    if (reset) error_q <= 1'b0;
    else       error_q <= error_d;
  end

  assign count = fifo_count;
  assign error = error_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed vector table, then random
// stimulus against a queue-based reference model.
module tb_reg_scoreboard;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk;
  logic             reset;
  logic [4:0]       rs1_address, rs2_address, issue_rd, retire_rd;
  logic             uses_rs1, uses_rs2, issue_valid, retire_valid, flush;
  logic [CNT_W-1:0] flush_count;
  logic             stall;
  logic [CNT_W-1:0] count;
  logic [31:0]      busy_mask;
  logic             error;

  int n_checks = 0;
  int n_fail   = 0;

  reg_scoreboard #(
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rs1_address (rs1_address),
    .rs2_address (rs2_address),
    .uses_rs1    (uses_rs1),
    .uses_rs2    (uses_rs2),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .stall       (stall),
    .retire_valid(retire_valid),
    .retire_rd   (retire_rd),
    .flush       (flush),
    .flush_count (flush_count),
    .count       (count),
    .busy_mask   (busy_mask),
    .error       (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          iv;
    int          ird;
    bit          u1;
    int          rs1;
    bit          u2;
    int          rs2;
    bit          rv;
    int          rrd;
    bit          fl;
    int          fc;
    bit          e_stall;  // combinational, this cycle
    int          e_count;  // after the edge
    int unsigned e_busy;   // after the edge
    bit          e_err;    // after the edge
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input bit rst, input bit iv, input int ird,
                              input bit u1, input int rs1, input bit u2, input int rs2,
                              input bit rv, input int rrd, input bit fl, input int fc,
                              input bit es, input int ec, input int unsigned eb,
                              input bit ee);
    vec_t v;
    v.rst = rst; v.iv = iv; v.ird = ird; v.u1 = u1; v.rs1 = rs1; v.u2 = u2; v.rs2 = rs2;
    v.rv = rv; v.rrd = rrd; v.fl = fl; v.fc = fc;
    v.e_stall = es; v.e_count = ec; v.e_busy = eb; v.e_err = ee;
    tbl.push_back(v);
  endfunction

  task automatic apply(input vec_t v);
    reset        = v.rst;
    issue_valid  = v.iv;
    issue_rd     = 5'(v.ird);
    uses_rs1     = v.u1;
    rs1_address  = 5'(v.rs1);
    uses_rs2     = v.u2;
    rs2_address  = 5'(v.rs2);
    retire_valid = v.rv;
    retire_rd    = 5'(v.rrd);
    flush        = v.fl;
    flush_count  = CNT_W'(v.fc);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Reference model: ordered list of in-flight destinations plus sticky error.
  int q[$];
  bit m_err;

  function automatic bit m_hit(input bit u, input int rs, input bit rv);
    if (!u || rs == 0) return 1'b0;
    foreach (q[k]) begin
      if (q[k] == rs && !(k == 0 && rv)) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic bit m_stall(input vec_t v);
    bit full;
    full = (q.size() == DEPTH) && !v.rv;
    return v.iv && (m_hit(v.u1, v.rs1, v.rv) || m_hit(v.u2, v.rs2, v.rv) || full || v.fl);
  endfunction

  function automatic logic [31:0] m_busy();
    logic [31:0] b;
    b = '0;
    foreach (q[k]) b[q[k]] = 1'b1;
    b[0] = 1'b0;
    return b;
  endfunction

  function automatic void m_step(input vec_t v);
    bit accept;
    int drop;
    if (v.rst) begin
      q.delete();
      m_err = 1'b0;
      return;
    end
    accept = v.iv && !m_stall(v);
    if (v.rv) begin
      if (q.size() == 0) m_err = 1'b1;
      else begin
        if (q[0] != v.rrd) m_err = 1'b1;
        void'(q.pop_front());
      end
    end
    if (v.fl) begin
      drop = (v.fc < q.size()) ? v.fc : q.size();
      repeat (drop) void'(q.pop_back());
    end else if (accept) begin
      q.push_back(v.ird);
    end
  endfunction

  initial begin
    vec_t v;

    // rst iv ird u1 rs1 u2 rs2 rv rrd fl fc | stall count busy err
    add(1, 0,  0, 0,  0, 0,  0, 0,  0, 0, 0,  0, 0, 32'h0,    0);
    add(0, 1,  5, 0,  0, 0,  0, 0,  0, 0, 0,  0, 1, 32'h20,   0);
    add(0, 1,  9, 1,  5, 0,  0, 0,  0, 0, 0,  1, 1, 32'h20,   0);
    add(0, 1,  9, 1,  5, 0,  0, 1,  5, 0, 0,  0, 1, 32'h200,  0);
    add(0, 0,  0, 0,  0, 0,  0, 1,  9, 0, 0,  0, 0, 32'h0,    0);
    add(0, 1,  0, 0,  0, 0,  0, 0,  0, 0, 0,  0, 1, 32'h0,    0);
    add(0, 1,  0, 1,  0, 1,  0, 0,  0, 0, 0,  0, 2, 32'h0,    0);
    add(0, 0,  0, 0,  0, 0,  0, 1,  0, 0, 0,  0, 1, 32'h0,    0);
    add(0, 0,  0, 0,  0, 0,  0, 1,  0, 0, 0,  0, 0, 32'h0,    0);
    add(0, 1,  1, 0,  0, 0,  0, 0,  0, 0, 0,  0, 1, 32'h2,    0);
    add(0, 1,  2, 0,  0, 0,  0, 0,  0, 0, 0,  0, 2, 32'h6,    0);
    add(0, 1,  3, 0,  0, 0,  0, 0,  0, 0, 0,  0, 3, 32'hE,    0);
    add(0, 1,  4, 0,  0, 0,  0, 0,  0, 0, 0,  0, 4, 32'h1E,   0);
    add(0, 1,  5, 0,  0, 0,  0, 0,  0, 0, 0,  1, 4, 32'h1E,   0);
    add(0, 1,  5, 0,  0, 0,  0, 1,  1, 0, 0,  0, 4, 32'h3C,   0);
    add(0, 0,  0, 0,  0, 0,  0, 1,  2, 0, 0,  0, 3, 32'h38,   0);
    add(0, 0,  0, 0,  0, 0,  0, 1,  3, 0, 0,  0, 2, 32'h30,   0);
    add(0, 0,  0, 0,  0, 0,  0, 1,  4, 0, 0,  0, 1, 32'h20,   0);
    add(0, 0,  0, 0,  0, 0,  0, 1,  5, 0, 0,  0, 0, 32'h0,    0);
    add(0, 1,  7, 0,  0, 0,  0, 0,  0, 0, 0,  0, 1, 32'h80,   0);
    add(0, 1,  8, 0,  0, 0,  0, 0,  0, 0, 0,  0, 2, 32'h180,  0);
    add(0, 1,  9, 0,  0, 0,  0, 0,  0, 0, 0,  0, 3, 32'h380,  0);
    add(0, 1, 10, 0,  0, 0,  0, 0,  0, 1, 2,  1, 1, 32'h80,   0);
    add(0, 1, 11, 0,  0, 0,  0, 0,  0, 0, 0,  0, 2, 32'h880,  0);
    add(0, 0,  0, 0,  0, 0,  0, 1,  7, 1, 3,  0, 0, 32'h0,    0);
    add(0, 0,  0, 0,  0, 0,  0, 1,  0, 0, 0,  0, 0, 32'h0,    1);
    add(0, 1,  7, 0,  0, 0,  0, 0,  0, 0, 0,  0, 1, 32'h80,   1);
    add(0, 0,  0, 0,  0, 0,  0, 1,  6, 0, 0,  0, 0, 32'h0,    1);
    add(0, 1, 12, 0,  0, 0,  0, 0,  0, 0, 0,  0, 1, 32'h1000, 1);
    add(1, 1, 13, 0,  0, 0,  0, 0,  0, 0, 0,  0, 0, 32'h0,    0);
    add(0, 1,  0, 1, 12, 0,  0, 0,  0, 0, 0,  0, 1, 32'h0,    0);
    add(0, 1, 14, 0,  0, 0,  0, 0,  0, 0, 0,  0, 2, 32'h4000, 0);
    add(0, 1,  2, 0,  0, 1, 14, 1,  0, 0, 0,  1, 1, 32'h4000, 0);
    add(0, 1,  2, 0,  0, 1, 14, 1, 14, 0, 0,  0, 1, 32'h4,    0);
    add(0, 0,  0, 0,  0, 0,  0, 1,  2, 0, 0,  0, 0, 32'h0,    0);

    foreach (tbl[i]) begin
      apply(tbl[i]);
      @(negedge clk);
      check($sformatf("vec%0d stall", i), 32'(stall), 32'(tbl[i].e_stall));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d count", i), 32'(count), 32'(tbl[i].e_count));
      check($sformatf("vec%0d busy_mask", i), busy_mask, tbl[i].e_busy);
      check($sformatf("vec%0d error", i), 32'(error), 32'(tbl[i].e_err));
    end

    // Random phase starts from a clean reset so the model and DUT agree.
    v = '{default: 0};
    v.rst = 1'b1;
    apply(v);
    @(posedge clk);
    #1;
    q.delete();
    m_err = 1'b0;

    for (int c = 0; c < 3000; c++) begin
      v.rst = ($urandom_range(0, 199) == 0);
      v.iv  = 1'($urandom_range(0, 1));
      v.ird = int'($urandom_range(0, 7));
      v.u1  = 1'($urandom_range(0, 1));
      v.rs1 = int'($urandom_range(0, 7));
      v.u2  = 1'($urandom_range(0, 1));
      v.rs2 = int'($urandom_range(0, 7));
      v.rv  = ($urandom_range(0, 9) < 4);
      if (q.size() > 0 && $urandom_range(0, 19) != 0) v.rrd = q[0];
      else v.rrd = int'($urandom_range(0, 7));
      v.fl  = ($urandom_range(0, 9) == 0);
      v.fc  = int'($urandom_range(0, DEPTH));
      apply(v);
      @(negedge clk);
      check($sformatf("rnd%0d stall", c), 32'(stall), 32'(m_stall(v)));
      check($sformatf("rnd%0d count", c), 32'(count), 32'(q.size()));
      check($sformatf("rnd%0d busy_mask", c), busy_mask, m_busy());
      check($sformatf("rnd%0d error", c), 32'(error), 32'(m_err));
      m_step(v);
      @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
